// File: rtl/alu_mul_sequencer.sv
// Multi-cycle 32x32 -> 64-bit shift-add multiply controller.
// Drives an external combinational ALU through its A/B/FS/C0 ports and
// registers its F result and carry-out on every busy cycle. Signed
// operands are converted to magnitudes before the shift-add loop, and the
// 64-bit product is negated afterwards when the operand signs differ.
module alu_mul_sequencer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned COUNT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                signed_mode,
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W-1:0] product,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [3:0]          alu_fs,
    output logic                alu_c0,
    input  logic [DATA_W-1:0]   alu_f,
    input  logic [3:0]          alu_status
);

    typedef enum logic [2:0] {
        IDLE,
        NEG_A,
        NEG_B,
        RUN,
        NEG_LO,
        NEG_HI,
        DONE
    } state_t;

    localparam logic [3:0] FS_ADD     = 4'b0000;
    localparam logic [3:0] FS_ADD_INV = 4'b0001;

    state_t              state;
    logic [DATA_W-1:0]   m;
    logic [DATA_W-1:0]   q;
    logic [DATA_W-1:0]   hi;
    logic [COUNT_W-1:0]  cnt;
    logic                neg_b;
    logic                sgn;
    logic                cy;

    logic                alu_carry;
    logic [2*DATA_W-1:0] run_next;
    logic                unused_status;

    // Only the carry flag participates in the algorithm; V, N and Z are ignored.
    assign alu_carry     = alu_status[2];
    assign unused_status = ^{alu_status[3], alu_status[1:0]};

    // One shift-add step: new HI is the ALU sum with its carry shifted in,
    // the low bit of the sum drops into the top of Q.
    assign run_next = {alu_carry, alu_f, q[DATA_W-1:1]};

    // ALU drive decoded from state and registers; all-zero when not operating.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_fs = FS_ADD;
        alu_c0 = 1'b0;
        case (state)
            NEG_A: begin
                alu_a  = m;
                alu_b  = '1;
                alu_fs = FS_ADD_INV;
                alu_c0 = 1'b1;
            end
            NEG_B: begin
                alu_a  = q;
                alu_b  = '1;
                alu_fs = FS_ADD_INV;
                alu_c0 = 1'b1;
            end
            RUN: begin
                alu_a  = hi;
                alu_b  = q[0] ? m : '0;
                alu_fs = FS_ADD;
                alu_c0 = 1'b0;
            end
            NEG_LO: begin
                alu_a  = q;
                alu_b  = '1;
                alu_fs = FS_ADD_INV;
                alu_c0 = 1'b1;
            end
            NEG_HI: begin
                alu_a  = hi;
                alu_b  = '1;
                alu_fs = FS_ADD_INV;
                alu_c0 = cy;
            end
            default: begin
                alu_a  = '0;
                alu_b  = '0;
                alu_fs = FS_ADD;
                alu_c0 = 1'b0;
            end
        endcase
    end

    // Sequencer state, datapath registers and registered status outputs.
    // product is loaded on the edge entering DONE so it is valid alongside done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            m       <= '0;
            q       <= '0;
            hi      <= '0;
            cnt     <= '0;
            neg_b   <= 1'b0;
            sgn     <= 1'b0;
            cy      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= op_a;
                        q     <= op_b;
                        hi    <= '0;
                        cnt   <= '0;
                        neg_b <= signed_mode & op_b[DATA_W-1];
                        sgn   <= (signed_mode & op_a[DATA_W-1]) ^ (signed_mode & op_b[DATA_W-1]);
                        busy  <= 1'b1;
                        if (signed_mode & op_a[DATA_W-1])
                            state <= NEG_A;
                        else if (signed_mode & op_b[DATA_W-1])
                            state <= NEG_B;
                        else
                            state <= RUN;
                    end
                end
                NEG_A: begin
                    m     <= alu_f;
                    state <= neg_b ? NEG_B : RUN;
                end
                NEG_B: begin
                    q     <= alu_f;
                    state <= RUN;
                end
                RUN: begin
                    {hi, q} <= run_next;
                    cnt     <= cnt + 1'b1;
                    if (cnt == COUNT_W'(DATA_W - 1)) begin
                        if (sgn) begin
                            state <= NEG_LO;
                        end else begin
                            state   <= DONE;
                            done    <= 1'b1;
                            product <= run_next;
                        end
                    end
                end
                NEG_LO: begin
                    q     <= alu_f;
                    cy    <= alu_carry;
                    state <= NEG_HI;
                end
                NEG_HI: begin
                    hi      <= alu_f;
                    product <= {alu_f, q};
                    done    <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
